// File: rtl/avl_imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// avl_imem_dmem_arbiter
//
// Shares one pipelined Avalon-MM slave port between the core's instruction
// master (imem) and data master (dmem).
//
// Arbitration:
//   - Round-robin between the two masters. When both are eligible, the one
//     that was not granted last time wins.
//   - If the slave stalls a granted command, the grant stays locked to that
//     master until the command is accepted.
//   - Grant is purely combinational, so it adds no latency.
//
// Read responses:
//   - An in-order tag FIFO records which master issued each accepted read.
//   - Pipelined read responses are steered back to the issuing master by
//     popping the head of that FIFO.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   imem_* / dmem_*       Avalon-MM slave-side ports facing the core's masters
//                         (read, write, address, writedata, byteenable in;
//                          waitrequest, readdata, readdatavalid, response out)
//   s_*                   Avalon-MM master-side port facing the shared slave
//   err_orphan            sticky: a read response arrived with nothing pending
// ---------------------------------------------------------------------------
module avl_imem_dmem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                imem_read,
    input  logic                imem_write,
    input  logic [ADDR_W-1:0]   imem_address,
    input  logic [DATA_W-1:0]   imem_writedata,
    input  logic [DATA_W/8-1:0] imem_byteenable,
    output logic                imem_waitrequest,
    output logic [DATA_W-1:0]   imem_readdata,
    output logic                imem_readdatavalid,
    output logic [1:0]          imem_response,

    input  logic                dmem_read,
    input  logic                dmem_write,
    input  logic [ADDR_W-1:0]   dmem_address,
    input  logic [DATA_W-1:0]   dmem_writedata,
    input  logic [DATA_W/8-1:0] dmem_byteenable,
    output logic                dmem_waitrequest,
    output logic [DATA_W-1:0]   dmem_readdata,
    output logic                dmem_readdatavalid,
    output logic [1:0]          dmem_response,

    output logic                s_read,
    output logic                s_write,
    output logic [ADDR_W-1:0]   s_address,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    input  logic [1:0]          s_response,

    output logic                err_orphan
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;

    localparam logic ID_IMEM = 1'b0;
    localparam logic ID_DMEM = 1'b1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic             last_grant_reg;
    logic             lock_reg;
    logic             lock_id_reg;
    logic             tag_reg [MAX_PENDING];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             err_orphan_reg;

    // -----------------------------------------------------------------------
    // Eligibility and grant
    // -----------------------------------------------------------------------
    logic read_room;
    logic imem_elig;
    logic dmem_elig;
    logic grant_valid;
    logic grant_id;
    logic grant_active;

    // Reads are throttled on the registered count only. A response popping
    // in the same cycle does not free a slot until the next cycle, which
    // keeps the FIFO full flag off the slave's response path.
    assign read_room = (count_reg < CNT_W'(MAX_PENDING));
    assign imem_elig = (imem_read | imem_write) & (~imem_read | read_room);
    assign dmem_elig = (dmem_read | dmem_write) & (~dmem_read | read_room);

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ID_IMEM;
        if (lock_reg) begin
            grant_valid = 1'b1;
            grant_id    = lock_id_reg;
        end else if (imem_elig && dmem_elig) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant_reg;
        end else if (imem_elig) begin
            grant_valid = 1'b1;
            grant_id    = ID_IMEM;
        end else if (dmem_elig) begin
            grant_valid = 1'b1;
            grant_id    = ID_DMEM;
        end
    end

    // The slave must see no command while reset is held, even if the
    // masters are already requesting, so the grant is qualified by rst_n.
    assign grant_active = rst_n & grant_valid;

    // -----------------------------------------------------------------------
    // Command path to the slave
    // -----------------------------------------------------------------------
    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_writedata;
    logic [BE_W-1:0]   sel_byteenable;

    always_comb begin
        sel_read       = 1'b0;
        sel_write      = 1'b0;
        sel_address    = '0;
        sel_writedata  = '0;
        sel_byteenable = '0;
        if (grant_active) begin
            if (grant_id == ID_DMEM) begin
                sel_read       = dmem_read;
                sel_write      = dmem_write;
                sel_address    = dmem_address;
                sel_writedata  = dmem_writedata;
                sel_byteenable = dmem_byteenable;
            end else begin
                sel_read       = imem_read;
                sel_write      = imem_write;
                sel_address    = imem_address;
                sel_writedata  = imem_writedata;
                sel_byteenable = imem_byteenable;
            end
        end
    end

    // An illegal simultaneous read+write is issued as a read only.
    assign s_read       = sel_read;
    assign s_write      = sel_write & ~sel_read;
    assign s_address    = sel_address;
    assign s_writedata  = sel_writedata;
    assign s_byteenable = sel_byteenable;

    assign imem_waitrequest = ~(grant_active && grant_id == ID_IMEM) | s_waitrequest;
    assign dmem_waitrequest = ~(grant_active && grant_id == ID_DMEM) | s_waitrequest;

    logic s_cmd;
    logic accept;
    logic stall;
    logic push;

    assign s_cmd  = s_read | s_write;
    assign accept = s_cmd & ~s_waitrequest;
    assign stall  = s_cmd & s_waitrequest;
    assign push   = accept & s_read;

    // -----------------------------------------------------------------------
    // Response routing
    // -----------------------------------------------------------------------
    logic pop;
    logic orphan;
    logic owner;

    assign pop    = rst_n & s_readdatavalid & (count_reg != '0);
    assign orphan = s_readdatavalid & (count_reg == '0);
    assign owner  = tag_reg[rd_ptr_reg];

    assign imem_readdatavalid = pop & (owner == ID_IMEM);
    assign dmem_readdatavalid = pop & (owner == ID_DMEM);
    assign imem_readdata      = imem_readdatavalid ? s_readdata : '0;
    assign dmem_readdata      = dmem_readdatavalid ? s_readdata : '0;
    assign imem_response      = imem_readdatavalid ? s_response : 2'b00;
    assign dmem_response      = dmem_readdatavalid ? s_response : 2'b00;

    assign err_orphan = err_orphan_reg;

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= ID_DMEM;
            lock_reg       <= 1'b0;
            lock_id_reg    <= ID_IMEM;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            err_orphan_reg <= 1'b0;
            for (int i = 0; i < MAX_PENDING; i++) begin
                tag_reg[i] <= ID_IMEM;
            end
        end else begin
            if (accept) begin
                lock_reg       <= 1'b0;
                last_grant_reg <= grant_id;
            end else if (stall) begin
                lock_reg    <= 1'b1;
                lock_id_reg <= grant_id;
            end

            if (push) begin
                tag_reg[wr_ptr_reg] <= grant_id;
                wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase

            if (orphan) begin
                err_orphan_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avl_imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for avl_imem_dmem_arbiter.
// Directed scenarios with hand-derived expectations, plus a randomized run
// checked against a queue-based reference model of the arbitration rules.
// Inputs change 1 time unit after the rising edge. Outputs are sampled
// 4 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_avl_imem_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int MAXP   = 4;
    localparam int OW     = 143;

    logic              clk;
    logic              rst_n;
    logic              imem_read, imem_write;
    logic [ADDR_W-1:0] imem_address;
    logic [DATA_W-1:0] imem_writedata;
    logic [BE_W-1:0]   imem_byteenable;
    logic              imem_waitrequest;
    logic [DATA_W-1:0] imem_readdata;
    logic              imem_readdatavalid;
    logic [1:0]        imem_response;
    logic              dmem_read, dmem_write;
    logic [ADDR_W-1:0] dmem_address;
    logic [DATA_W-1:0] dmem_writedata;
    logic [BE_W-1:0]   dmem_byteenable;
    logic              dmem_waitrequest;
    logic [DATA_W-1:0] dmem_readdata;
    logic              dmem_readdatavalid;
    logic [1:0]        dmem_response;
    logic              s_read, s_write;
    logic [ADDR_W-1:0] s_address;
    logic [DATA_W-1:0] s_writedata;
    logic [BE_W-1:0]   s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;
    logic [1:0]        s_response;
    logic              err_orphan;

    int errors = 0;
    int checks = 0;

    avl_imem_dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_read(imem_read), .imem_write(imem_write), .imem_address(imem_address),
        .imem_writedata(imem_writedata), .imem_byteenable(imem_byteenable),
        .imem_waitrequest(imem_waitrequest), .imem_readdata(imem_readdata),
        .imem_readdatavalid(imem_readdatavalid), .imem_response(imem_response),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_writedata(dmem_writedata), .dmem_byteenable(dmem_byteenable),
        .dmem_waitrequest(dmem_waitrequest), .dmem_readdata(dmem_readdata),
        .dmem_readdatavalid(dmem_readdatavalid), .dmem_response(dmem_response),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .s_response(s_response),
        .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_all();
        imem_read = 0; imem_write = 0; imem_address = '0; imem_writedata = '0; imem_byteenable = '0;
        dmem_read = 0; dmem_write = 0; dmem_address = '0; dmem_writedata = '0; dmem_byteenable = '0;
        s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0; s_response = 2'b00;
    endtask

    // Holds reset for two edges and leaves time at rising edge + 1.
    task automatic do_reset();
        idle_all();
        rst_n = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 0;
        imem_read = 1; imem_address = 32'h10; dmem_write = 1; dmem_address = 32'h20;
        s_readdatavalid = 1; s_readdata = 32'h1234;
        #3;
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL reset_s_read: got %b expected 0", s_read); end
        checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL reset_s_write: got %b expected 0", s_write); end
        checks++; if ({imem_waitrequest, dmem_waitrequest} !== 2'b11) begin errors++; $display("FAIL reset_waitrequest: got %b expected 11", {imem_waitrequest, dmem_waitrequest}); end
        checks++; if ({imem_readdatavalid, dmem_readdatavalid} !== 2'b00) begin errors++; $display("FAIL reset_rdv: got %b expected 00", {imem_readdatavalid, dmem_readdatavalid}); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan: got %b expected 0", err_orphan); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        imem_read = 1; imem_address = 32'h100; imem_byteenable = 4'hF;
        #3;
        checks++; if ({s_read, s_address} !== {1'b1, 32'h100}) begin errors++; $display("FAIL single_cmd0: got %b/%h expected 1/00000100", s_read, s_address); end
        checks++; if ({imem_waitrequest, dmem_waitrequest} !== 2'b01) begin errors++; $display("FAIL single_wait0: got %b expected 01", {imem_waitrequest, dmem_waitrequest}); end
        next_cycle();
        imem_address = 32'h104;
        #3;
        checks++; if ({s_read, s_address, imem_waitrequest} !== {1'b1, 32'h104, 1'b0}) begin errors++; $display("FAIL single_cmd1: got %b/%h/%b expected 1/00000104/0", s_read, s_address, imem_waitrequest); end
        next_cycle();
        imem_read = 0; s_readdatavalid = 1; s_readdata = 32'hA;
        #3;
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL single_idle: got s_read=%b expected 0", s_read); end
        checks++; if ({imem_readdatavalid, imem_readdata} !== {1'b1, 32'hA}) begin errors++; $display("FAIL single_rsp0: got %b/%h expected 1/0000000a", imem_readdatavalid, imem_readdata); end
        checks++; if ({dmem_readdatavalid, dmem_readdata} !== {1'b0, 32'h0}) begin errors++; $display("FAIL single_dmem0: got %b/%h expected 0/00000000", dmem_readdatavalid, dmem_readdata); end
        next_cycle();
        s_readdata = 32'hB;
        #3;
        checks++; if ({imem_readdatavalid, imem_readdata, dmem_readdatavalid} !== {1'b1, 32'hB, 1'b0}) begin errors++; $display("FAIL single_rsp1: got %b/%h/%b expected 1/0000000b/0", imem_readdatavalid, imem_readdata, dmem_readdatavalid); end
        next_cycle();
        s_readdatavalid = 0; s_readdata = 32'hFFFF;
        #3;
        checks++; if ({imem_readdatavalid, imem_readdata} !== {1'b0, 32'h0}) begin errors++; $display("FAIL single_quiet: got %b/%h expected 0/00000000", imem_readdatavalid, imem_readdata); end
        $display("test_single done");
    endtask

    task automatic test_contention();
        int          due_q[$];
        logic [31:0] dat_q[$];
        bit          own_q[$];
        logic [31:0] ia, da, ea;
        bit          g, own;
        do_reset();
        ia = 32'h1000; da = 32'h2000;
        for (int k = 0; k < 12; k++) begin
            imem_read = (k < 8); dmem_read = (k < 8);
            imem_address = ia; dmem_address = da;
            s_readdatavalid = 0;
            if (due_q.size() > 0 && due_q[0] == k) begin
                s_readdatavalid = 1; s_readdata = dat_q[0];
            end
            #3;
            if (k < 8) begin
                g  = k[0];
                ea = g ? da : ia;
                checks++; if ({s_read, s_address} !== {1'b1, ea}) begin errors++; $display("FAIL contention_grant cyc %0d: got %b/%h expected 1/%h", k, s_read, s_address, ea); end
                checks++; if ({imem_waitrequest, dmem_waitrequest} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_wait cyc %0d: got %b expected %b", k, {imem_waitrequest, dmem_waitrequest}, (g ? 2'b10 : 2'b01)); end
            end
            if (s_readdatavalid) begin
                own = own_q[0];
                checks++; if ({imem_readdatavalid, dmem_readdatavalid} !== (own ? 2'b01 : 2'b10)) begin errors++; $display("FAIL contention_route cyc %0d: got %b expected %b", k, {imem_readdatavalid, dmem_readdatavalid}, (own ? 2'b01 : 2'b10)); end
                checks++; if ((own ? dmem_readdata : imem_readdata) !== dat_q[0]) begin errors++; $display("FAIL contention_data cyc %0d: got %h expected %h", k, (own ? dmem_readdata : imem_readdata), dat_q[0]); end
                void'(due_q.pop_front()); void'(dat_q.pop_front()); void'(own_q.pop_front());
            end else begin
                checks++; if ({imem_readdatavalid, dmem_readdatavalid} !== 2'b00) begin errors++; $display("FAIL contention_norsp cyc %0d: got %b expected 00", k, {imem_readdatavalid, dmem_readdatavalid}); end
            end
            if (k < 8) begin
                due_q.push_back(k + 2); dat_q.push_back(ea ^ 32'hA5A5_0000); own_q.push_back(g);
                if (g) da = da + 4; else ia = ia + 4;
            end
            next_cycle();
        end
        $display("test_contention done");
    endtask

    task automatic test_lock();
        do_reset();
        dmem_write = 1; dmem_address = 32'h3000; dmem_writedata = 32'hCAFE; dmem_byteenable = 4'h3;
        for (int k = 0; k < 4; k++) begin
            s_waitrequest = (k < 3);
            if (k > 0) begin imem_read = 1; imem_address = 32'h4000; end
            #3;
            checks++; if ({s_write, s_read, s_address, s_writedata, s_byteenable} !== {2'b10, 32'h3000, 32'hCAFE, 4'h3}) begin errors++; $display("FAIL lock_hold cyc %0d: got %b%b/%h/%h/%h expected 10/00003000/0000cafe/3", k, s_write, s_read, s_address, s_writedata, s_byteenable); end
            checks++; if ({imem_waitrequest, dmem_waitrequest} !== {1'b1, (k < 3)}) begin errors++; $display("FAIL lock_wait cyc %0d: got %b expected 1%b", k, {imem_waitrequest, dmem_waitrequest}, (k < 3)); end
            next_cycle();
        end
        dmem_address = 32'h3004;
        #3;
        checks++; if ({s_read, s_write, s_address, imem_waitrequest, dmem_waitrequest} !== {2'b10, 32'h4000, 2'b01}) begin errors++; $display("FAIL lock_after: got %b%b/%h/%b%b expected 10/00004000/01", s_read, s_write, s_address, imem_waitrequest, dmem_waitrequest); end
        next_cycle();
        imem_read = 0; s_readdatavalid = 1; s_readdata = 32'h77;
        #3;
        checks++; if ({imem_readdatavalid, imem_readdata, dmem_readdatavalid} !== {1'b1, 32'h77, 1'b0}) begin errors++; $display("FAIL lock_rsp: got %b/%h/%b expected 1/00000077/0", imem_readdatavalid, imem_readdata, dmem_readdatavalid); end
        checks++; if ({s_write, s_address, dmem_waitrequest} !== {1'b1, 32'h3004, 1'b0}) begin errors++; $display("FAIL lock_dmem2: got %b/%h/%b expected 1/00003004/0", s_write, s_address, dmem_waitrequest); end
        next_cycle();
        idle_all();
        $display("test_lock done");
    endtask

    task automatic test_full_fifo();
        do_reset();
        imem_read = 1;
        for (int k = 0; k < 4; k++) begin
            imem_address = 32'h500 + 32'(4 * k);
            #3;
            checks++; if ({s_read, imem_waitrequest} !== 2'b10) begin errors++; $display("FAIL full_fill cyc %0d: got %b expected 10", k, {s_read, imem_waitrequest}); end
            next_cycle();
        end
        imem_address = 32'h510; dmem_write = 1; dmem_address = 32'h600;
        #3;
        checks++; if ({imem_waitrequest, dmem_waitrequest, s_read, s_write, s_address} !== {4'b1001, 32'h600}) begin errors++; $display("FAIL full_block: got %b%b%b%b/%h expected 1001/00000600", imem_waitrequest, dmem_waitrequest, s_read, s_write, s_address); end
        next_cycle();
        dmem_write = 0; s_readdatavalid = 1; s_readdata = 32'hD0;
        #3;
        checks++; if ({imem_waitrequest, s_read} !== 2'b10) begin errors++; $display("FAIL full_samecycle: got %b expected 10", {imem_waitrequest, s_read}); end
        checks++; if ({imem_readdatavalid, imem_readdata} !== {1'b1, 32'hD0}) begin errors++; $display("FAIL full_rsp0: got %b/%h expected 1/000000d0", imem_readdatavalid, imem_readdata); end
        next_cycle();
        s_readdatavalid = 0;
        #3;
        checks++; if ({imem_waitrequest, s_read, s_address} !== {2'b01, 32'h510}) begin errors++; $display("FAIL full_unblock: got %b%b/%h expected 01/00000510", imem_waitrequest, s_read, s_address); end
        next_cycle();
        imem_read = 0;
        for (int k = 1; k <= 4; k++) begin
            s_readdatavalid = 1; s_readdata = 32'hD0 + 32'(k);
            #3;
            checks++; if ({imem_readdatavalid, imem_readdata, dmem_readdatavalid} !== {1'b1, 32'hD0 + 32'(k), 1'b0}) begin errors++; $display("FAIL full_drain %0d: got %b/%h/%b expected 1/%h/0", k, imem_readdatavalid, imem_readdata, dmem_readdatavalid, 32'hD0 + 32'(k)); end
            next_cycle();
        end
        s_readdatavalid = 0;
        #3;
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL full_no_orphan: got %b expected 0", err_orphan); end
        $display("test_full_fifo done");
    endtask

    task automatic test_orphan_reset();
        do_reset();
        s_readdatavalid = 1; s_readdata = 32'hEE;
        #3;
        checks++; if ({imem_readdatavalid, dmem_readdatavalid, imem_readdata, dmem_readdata} !== 66'h0) begin errors++; $display("FAIL orphan_novalid: got %b%b/%h/%h expected 00/0/0", imem_readdatavalid, dmem_readdatavalid, imem_readdata, dmem_readdata); end
        next_cycle();
        s_readdatavalid = 0;
        #3;
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_flag: got %b expected 1", err_orphan); end
        next_cycle();
        dmem_write = 1; dmem_address = 32'h900; s_waitrequest = 1;
        next_cycle();
        imem_read = 1; imem_address = 32'h700;
        #3;
        checks++; if ({s_write, s_address, imem_waitrequest} !== {1'b1, 32'h900, 1'b1}) begin errors++; $display("FAIL orphan_locked: got %b/%h/%b expected 1/00000900/1", s_write, s_address, imem_waitrequest); end
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b expected 1", err_orphan); end
        #1;
        rst_n = 0; s_readdatavalid = 1;
        #1;
        checks++; if ({s_read, s_write, imem_waitrequest, dmem_waitrequest} !== 4'b0011) begin errors++; $display("FAIL midreset_cmd: got %b expected 0011", {s_read, s_write, imem_waitrequest, dmem_waitrequest}); end
        checks++; if ({imem_readdatavalid, dmem_readdatavalid, err_orphan} !== 3'b000) begin errors++; $display("FAIL midreset_flags: got %b expected 000", {imem_readdatavalid, dmem_readdatavalid, err_orphan}); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1; s_readdatavalid = 0; s_waitrequest = 0;
        #3;
        checks++; if ({s_read, s_write, s_address} !== {2'b10, 32'h700}) begin errors++; $display("FAIL postreset_grant: got %b%b/%h expected 10/00000700", s_read, s_write, s_address); end
        next_cycle();
        idle_all();
        $display("test_orphan_reset done");
    endtask

    // Randomized run. Masters hold a command until it is accepted; the slave
    // returns read data in order after a random delay.
    task automatic test_random(input int n);
        bit          m_last, m_lock, m_lock_id, gv, g, ei, ed, pop, acc;
        bit          own_q[$];
        logic [31:0] sq_data[$];
        logic [1:0]  sq_resp[$];
        bit          i_act, d_act;
        logic [1:0]  i_kind, d_kind, g_kind;
        logic [31:0] i_addr, d_addr, i_wd, d_wd, g_addr, g_wd;
        logic [3:0]  i_be, d_be, g_be;
        logic        e_sr, e_sw, e_iw, e_dw, e_irdv, e_drdv;
        logic [OW-1:0] exp_v, act_v;
        int          accepted;
        do_reset();
        m_last = 1; m_lock = 0; m_lock_id = 0; accepted = 0;
        i_act = 0; d_act = 0; i_kind = 0; d_kind = 0;
        i_addr = 0; d_addr = 0; i_wd = 0; d_wd = 0; i_be = 0; d_be = 0;
        for (int k = 0; k < n; k++) begin
            if (!i_act && $urandom_range(0, 2) != 0) begin
                i_act = 1; i_kind = 2'($urandom_range(1, 3)); i_addr = $urandom; i_wd = $urandom; i_be = 4'($urandom);
            end
            if (!d_act && $urandom_range(0, 2) != 0) begin
                d_act = 1; d_kind = 2'($urandom_range(1, 3)); d_addr = $urandom; d_wd = $urandom; d_be = 4'($urandom);
            end
            imem_read = i_act & i_kind[0]; imem_write = i_act & i_kind[1];
            imem_address = i_addr; imem_writedata = i_wd; imem_byteenable = i_be;
            dmem_read = d_act & d_kind[0]; dmem_write = d_act & d_kind[1];
            dmem_address = d_addr; dmem_writedata = d_wd; dmem_byteenable = d_be;
            s_waitrequest = ($urandom_range(0, 3) == 0);
            s_readdatavalid = (sq_data.size() > 0) && ($urandom_range(0, 1) == 1);
            s_readdata = s_readdatavalid ? sq_data[0] : $urandom;
            s_response = s_readdatavalid ? sq_resp[0] : 2'($urandom);
            #3;
            // Reference: eligibility, round-robin choice, lock, in-order routing.
            ei = i_act && (!i_kind[0] || own_q.size() < MAXP);
            ed = d_act && (!d_kind[0] || own_q.size() < MAXP);
            gv = 1; g = 0;
            if (m_lock) g = m_lock_id;
            else if (ei && ed) g = !m_last;
            else if (ei) g = 0;
            else if (ed) g = 1;
            else gv = 0;
            g_kind = g ? d_kind : i_kind; g_addr = g ? d_addr : i_addr;
            g_wd = g ? d_wd : i_wd; g_be = g ? d_be : i_be;
            e_sr = gv && g_kind[0];
            e_sw = gv && (g_kind == 2'b10);
            e_iw = !(gv && !g) || s_waitrequest;
            e_dw = !(gv && g) || s_waitrequest;
            pop = s_readdatavalid && own_q.size() > 0;
            e_irdv = pop && !own_q[0];
            e_drdv = pop && own_q[0];
            exp_v = {e_sr, e_sw, gv ? g_addr : 32'h0, gv ? g_wd : 32'h0, gv ? g_be : 4'h0, e_iw, e_dw,
                     e_irdv, e_irdv ? s_readdata : 32'h0, e_irdv ? s_response : 2'b00,
                     e_drdv, e_drdv ? s_readdata : 32'h0, e_drdv ? s_response : 2'b00, 1'b0};
            act_v = {s_read, s_write, s_address, s_writedata, s_byteenable, imem_waitrequest, dmem_waitrequest,
                     imem_readdatavalid, imem_readdata, imem_response,
                     dmem_readdatavalid, dmem_readdata, dmem_response, err_orphan};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random cyc %0d: got %h expected %h", k, act_v, exp_v);
            end
            acc = gv && (e_sr || e_sw) && !s_waitrequest;
            if (acc) begin
                accepted++;
                m_last = g; m_lock = 0;
                if (e_sr) begin
                    own_q.push_back(g); sq_data.push_back($urandom); sq_resp.push_back(2'($urandom));
                end
                if (g) d_act = 0; else i_act = 0;
            end else if (gv && (e_sr || e_sw)) begin
                m_lock = 1; m_lock_id = g;
            end
            if (pop) begin
                void'(own_q.pop_front()); void'(sq_data.pop_front()); void'(sq_resp.pop_front());
            end
            next_cycle();
        end
        idle_all();
        $display("test_random done: %0d cycles, %0d commands accepted", n, accepted);
    endtask

    initial begin
        rst_n = 0;
        idle_all();
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_full_fifo();
        test_orphan_reset();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
